// File: rtl/fp_frame_max.sv
// Streaming sign/exponent/fraction maximum finder over valid/ready framed input.
// Optional FP_FRAME_MAX_ZERO_EQ_EN: +0 and -0 compare equal (earlier one kept).
module fp_frame_max #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 8,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_ovf
);
  localparam int M_W = EXP_W + FRAC_W;

  typedef enum logic [1:0] {EMPTY, ACC, DONE} state_t;

  state_t            state_q, state_d;
  logic              max_sign_q, max_sign_d;
  logic [M_W-1:0]    max_mag_q, max_mag_d;
  logic [IDX_W-1:0]  max_idx_q, max_idx_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              out_sign_q, out_sign_d;
  logic [M_W-1:0]    out_mag_q, out_mag_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_ovf_q, out_ovf_d;

  logic [M_W-1:0]    in_mag;
  logic              take;
  logic              nxt_sign;
  logic [M_W-1:0]    nxt_mag;
  logic [IDX_W-1:0]  nxt_idx;
  logic              nxt_ovf;

  // True when operand a strictly beats operand b; equality never replaces.
  function automatic logic beats(input logic sa, input logic [M_W-1:0] ma,
                                 input logic sb, input logic [M_W-1:0] mb);
    logic r;
    if (sa != sb)
      r = ~sa;
    else if (!sa)
      r = (ma > mb);
    else
      r = (ma < mb);
`ifdef FP_FRAME_MAX_ZERO_EQ_EN
    if (ma == '0 && mb == '0)
      r = 1'b0;
`endif
    return r;
  endfunction

  assign in_mag = {in_exp, in_frac};

  always_comb begin
    take     = beats(in_sign, in_mag, max_sign_q, max_mag_q);
    nxt_sign = take ? in_sign : max_sign_q;
    nxt_mag  = take ? in_mag  : max_mag_q;
    nxt_idx  = take ? cnt_q   : max_idx_q;
    // A beat arriving with the counter at zero in ACC means the index wrapped.
    nxt_ovf  = ovf_q | (cnt_q == '0);
  end

  always_comb begin
    state_d    = state_q;
    max_sign_d = max_sign_q;
    max_mag_d  = max_mag_q;
    max_idx_d  = max_idx_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    out_sign_d = out_sign_q;
    out_mag_d  = out_mag_q;
    out_idx_d  = out_idx_q;
    out_ovf_d  = out_ovf_q;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
          max_sign_d = in_sign;
          max_mag_d  = in_mag;
          max_idx_d  = '0;
          cnt_d      = IDX_W'(1);
          ovf_d      = 1'b0;
          if (in_last) begin
            out_sign_d = in_sign;
            out_mag_d  = in_mag;
            out_idx_d  = '0;
            out_ovf_d  = 1'b0;
            state_d    = DONE;
          end else begin
            state_d    = ACC;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          max_sign_d = nxt_sign;
          max_mag_d  = nxt_mag;
          max_idx_d  = nxt_idx;
          ovf_d      = nxt_ovf;
          cnt_d      = cnt_q + IDX_W'(1);
          if (in_last) begin
            out_sign_d = nxt_sign;
            out_mag_d  = nxt_mag;
            out_idx_d  = nxt_idx;
            out_ovf_d  = nxt_ovf;
            state_d    = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      max_sign_q <= 1'b0;
      max_mag_q  <= '0;
      max_idx_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      out_sign_q <= 1'b0;
      out_mag_q  <= '0;
      out_idx_q  <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      max_sign_q <= max_sign_d;
      max_mag_q  <= max_mag_d;
      max_idx_q  <= max_idx_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      out_sign_q <= out_sign_d;
      out_mag_q  <= out_mag_d;
      out_idx_q  <= out_idx_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign in_ready  = (state_q != DONE);
  assign out_sign  = out_sign_q;
  assign out_exp   = out_mag_q[M_W-1:FRAC_W];
  assign out_frac  = out_mag_q[FRAC_W-1:0];
  assign out_idx   = out_idx_q;
  assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_fp_frame_max.sv
// Bench for fp_frame_max: two instances (IDX_W 8 and 2) share stimulus and are
// checked every cycle against a frame-queue reference model.
module tb_fp_frame_max;
  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;
  localparam int IDX_A  = 8;
  localparam int IDX_B  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_sign = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [EXP_W-1:0]  in_exp = '0;
  logic [FRAC_W-1:0] in_frac = '0;

  logic in_ready_a, out_valid_a, out_sign_a, out_ovf_a;
  logic [EXP_W-1:0] out_exp_a;
  logic [FRAC_W-1:0] out_frac_a;
  logic [IDX_A-1:0] out_idx_a;
  logic in_ready_b, out_valid_b, out_sign_b, out_ovf_b;
  logic [EXP_W-1:0] out_exp_b;
  logic [FRAC_W-1:0] out_frac_b;
  logic [IDX_B-1:0] out_idx_b;

  always #5 clk = ~clk;

  fp_frame_max #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .IDX_W(IDX_A)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_sign(out_sign_a),
    .out_exp(out_exp_a), .out_frac(out_frac_a), .out_idx(out_idx_a), .out_ovf(out_ovf_a));

  fp_frame_max #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .IDX_W(IDX_B)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_sign(out_sign_b),
    .out_exp(out_exp_b), .out_frac(out_frac_b), .out_idx(out_idx_b), .out_ovf(out_ovf_b));

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [12:0] fq[$];
  logic        m_valid = 1'b0;
  logic        m_acc = 1'b0;
  logic [12:0] m_val = '0;
  int          m_idx_a = 0, m_idx_b = 0;
  logic        m_ovf_a = 1'b0, m_ovf_b = 1'b0;
  bit          started = 1'b0;

  // Map a sign/magnitude value onto a signed integer whose ordering is the max rule.
  function automatic int key(input logic [12:0] v);
    int m;
    m = int'(v[11:0]);
`ifdef FP_FRAME_MAX_ZERO_EQ_EN
    return v[12] ? -2 * m : 2 * m;
`else
    return v[12] ? -2 * m - 1 : 2 * m;
`endif
  endfunction

  always @(posedge clk) begin
    int best;
    m_acc = 1'b0;
    if (reset) begin
      fq.delete();
      m_valid = 1'b0;
      m_val = '0;
      m_idx_a = 0; m_idx_b = 0;
      m_ovf_a = 1'b0; m_ovf_b = 1'b0;
      started = 1'b1;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (in_valid) begin
      m_acc = 1'b1;
      fq.push_back({in_sign, in_exp, in_frac});
      if (in_last) begin
        best = 0;
        for (int i = 1; i < fq.size(); i++)
          if (key(fq[i]) > key(fq[best])) best = i;
        m_val   = fq[best];
        m_idx_a = best % (1 << IDX_A);
        m_idx_b = best % (1 << IDX_B);
        m_ovf_a = fq.size() > (1 << IDX_A);
        m_ovf_b = fq.size() > (1 << IDX_B);
        m_valid = 1'b1;
        fq.delete();
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready_a", 32'(in_ready_a), 32'(!m_valid));
      chk("in_ready_b", 32'(in_ready_b), 32'(!m_valid));
      chk("out_valid_a", 32'(out_valid_a), 32'(m_valid));
      chk("out_valid_b", 32'(out_valid_b), 32'(m_valid));
      chk("value_a", 32'({out_sign_a, out_exp_a, out_frac_a}), 32'(m_val));
      chk("value_b", 32'({out_sign_b, out_exp_b, out_frac_b}), 32'(m_val));
      chk("idx_a", 32'(out_idx_a), 32'(m_idx_a));
      chk("idx_b", 32'(out_idx_b), 32'(m_idx_b));
      chk("ovf_a", 32'(out_ovf_a), 32'(m_ovf_a));
      chk("ovf_b", 32'(out_ovf_b), 32'(m_ovf_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic s, input logic [3:0] e, input logic [7:0] f, input logic l);
    bit got;
    got = 1'b0;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_frac = f; in_last = l;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      got = m_acc;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL beat_timeout accepted=0 expected=1 t=%0t", $time);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_in_ready", 32'(in_ready_a), 32'd1);
    chk("reset_out_valid", 32'(out_valid_a), 32'd0);
    reset = 1'b0;
    tick();

    // Basic frame: max is (+,5,0x01) at index 1, valid right after last beat.
    beat(1'b0, 4'd3, 8'h10, 1'b0);
    beat(1'b0, 4'd5, 8'h01, 1'b0);
    beat(1'b1, 4'd7, 8'hFF, 1'b0);
    beat(1'b0, 4'd5, 8'h01, 1'b1);
    chk("t1_valid", 32'(out_valid_a), 32'd1);
    chk("t1_value", 32'({out_sign_a, out_exp_a, out_frac_a}), 32'h0501);
    chk("t1_idx", 32'(out_idx_a), 32'd1);
    chk("t1_ovf", 32'(out_ovf_a), 32'd0);
    tick();

    // All-negative frame.
    beat(1'b1, 4'd4, 8'h80, 1'b0);
    beat(1'b1, 4'd2, 8'h05, 1'b0);
    beat(1'b1, 4'd2, 8'h06, 1'b1);
    chk("t2_value", 32'({out_sign_a, out_exp_a, out_frac_a}), 32'h1205);
    chk("t2_idx", 32'(out_idx_a), 32'd1);
    tick();

    // Output backpressure with in_valid held high.
    out_ready = 1'b0;
    beat(1'b0, 4'd2, 8'h03, 1'b1);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 4'd15; in_frac = 8'hFF; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_in_ready", 32'(in_ready_a), 32'd0);
      chk("t3_hold", 32'({out_sign_a, out_exp_a, out_frac_a}), 32'h0203);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    chk("t3_release", 32'(in_ready_a), 32'd1);
    beat(1'b0, 4'd1, 8'h02, 1'b1);
    chk("t3_next", 32'({out_frac_a, out_idx_a}), 32'h0200);
    tick();

    // Overflow on the IDX_W=2 instance: 6 beats, max at beat 5.
    beat(1'b0, 4'd1, 8'h00, 1'b0);
    beat(1'b0, 4'd2, 8'h00, 1'b0);
    beat(1'b0, 4'd1, 8'h00, 1'b0);
    beat(1'b0, 4'd3, 8'h00, 1'b0);
    beat(1'b0, 4'd2, 8'h00, 1'b0);
    beat(1'b0, 4'd9, 8'h00, 1'b1);
    chk("t4_ovf_b", 32'(out_ovf_b), 32'd1);
    chk("t4_idx_b", 32'(out_idx_b), 32'd1);
    chk("t4_ovf_a", 32'(out_ovf_a), 32'd0);
    chk("t4_idx_a", 32'(out_idx_a), 32'd5);
    tick();

    // Signed zeros.
    beat(1'b1, 4'd0, 8'h00, 1'b0);
    beat(1'b0, 4'd0, 8'h00, 1'b1);
`ifdef FP_FRAME_MAX_ZERO_EQ_EN
    chk("t5_idx", 32'(out_idx_a), 32'd0);
    chk("t5_sign", 32'(out_sign_a), 32'd1);
`else
    chk("t5_idx", 32'(out_idx_a), 32'd1);
    chk("t5_sign", 32'(out_sign_a), 32'd0);
`endif
    tick();

    // Reset mid-frame, then single-beat frame.
    beat(1'b0, 4'd7, 8'h00, 1'b0);
    beat(1'b0, 4'd8, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_no_result", 32'(out_valid_a), 32'd0);
    beat(1'b0, 4'd1, 8'h01, 1'b1);
    chk("t6_valid", 32'(out_valid_a), 32'd1);
    chk("t6_value", 32'({out_sign_a, out_exp_a, out_frac_a, out_idx_a}), 32'h010100);
    tick();

    // Randomized traffic with small magnitudes to provoke ties and signed zeros.
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_sign   = 1'($urandom % 2);
      in_exp    = 4'($urandom_range(0, 2));
      in_frac   = 8'($urandom_range(0, 2));
      in_last   = ($urandom % 8) == 0;
      out_ready = ($urandom % 3) != 0;
      reset     = ($urandom % 600) == 0;
      tick();
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
